// File: rtl/yp_uart_pkg.sv
// Shared definitions for the UART transmitter and its request arbiter.
// Holds the arbiter state encoding, the default character width and an index-wrap helper.
package yp_uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_START     = 2'd1,
        ARB_WAIT_DONE = 2'd2,
        ARB_RESP      = 2'd3
    } arb_state_e;

    // Single-step modulo: callers never pass an index of 2*n or more.
    function automatic int wrap_index(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/yp_rr_picker.sv
// Combinational round-robin selector: the first requester above last_i (wrapping)
// wins, and last_i itself has the lowest priority.
module yp_rr_picker
    import yp_uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   win_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_shift;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       shamt;
    int                   first_d;

    // Rotate so that bit 0 of req_rot is requester last_i+1.
    assign req_dbl   = {req_i, req_i};
    assign shamt     = {1'b0, last_i} + (IDX_W + 1)'(1);
    assign req_shift = req_dbl >> shamt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign req_rot[gi] = req_shift[gi];
    end

    always_comb begin
        first_d = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                first_d = j;
            end
        end
    end

    assign valid_o = |req_i;
    assign win_o   = IDX_W'(wrap_index(int'(last_i) + 1 + first_d, NUM_REQ));

endmodule

// File: rtl/yp_uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a watchdog that aborts a transfer whose completion never arrives.
module yp_uart_tx_arb
    import yp_uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic                          o_timeout,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy,
    output logic                          o_tx_start,
    output logic [DATA_WIDTH-1:0]         o_tx_data_in,
    input  logic                          i_tx_done
);

    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e            state_q;
    logic [IDX_W-1:0]      grant_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  tx_start_q;
    logic                  timeout_q;
    logic [NUM_REQ-1:0]    ack_q;

    logic [IDX_W-1:0]      win_d;
    logic                  win_valid_d;
    logic [DATA_WIDTH-1:0] req_slice [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_slice[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    yp_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (i_req),
        .last_i  (last_grant_q),
        .win_o   (win_d),
        .valid_o (win_valid_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_LAST;
            data_q       <= '0;
            cnt_q        <= '0;
            tx_start_q   <= 1'b0;
            timeout_q    <= 1'b0;
            ack_q        <= '0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (win_valid_d) begin
                        // Character is captured here, so later data changes cannot leak in.
                        grant_q    <= win_d;
                        data_q     <= req_slice[win_d];
                        tx_start_q <= 1'b1;
                        state_q    <= ARB_START;
                    end
                end
                ARB_START: begin
                    cnt_q   <= '0;
                    state_q <= ARB_WAIT_DONE;
                end
                ARB_WAIT_DONE: begin
                    // Done wins over a simultaneous watchdog expiry.
                    if (i_tx_done) begin
                        ack_q   <= NUM_REQ'(1) << grant_q;
                        state_q <= ARB_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ARB_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    last_grant_q <= grant_q;
                    state_q      <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_ack        = ack_q;
    assign o_timeout    = timeout_q;
    assign o_grant_id   = grant_q;
    assign o_busy       = (state_q != ARB_IDLE);
    assign o_tx_start   = tx_start_q;
    assign o_tx_data_in = data_q;

endmodule

// File: tb/tb_yp_uart_tx_arb.sv
// Directed bench for yp_uart_tx_arb: the transmitter is modelled by hand-timed i_tx_done pulses
// and every expected value is a hand-computed constant.
module tb_yp_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int TO      = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [31:0]   req_data;
    logic [3:0]    ack;
    logic          timeout;
    logic [1:0]    gid;
    logic          busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    yp_uart_tx_arb #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_req_data   (req_data),
        .o_ack        (ack),
        .o_timeout    (timeout),
        .o_grant_id   (gid),
        .o_busy       (busy),
        .o_tx_start   (tx_start),
        .o_tx_data_in (tx_data),
        .i_tx_done    (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input int budget, output int waited);
        waited = 0;
        while (!tx_start && waited < budget) begin
            tick();
            waited++;
        end
        chk("start_seen", {31'd0, tx_start}, 32'd1);
    endtask

    // Waits for the grant, returns i_tx_done `delay` cycles after the start cycle, checks the ack.
    task automatic run_xfer(input string tag, input int exp_id, input logic [7:0] exp_data,
                            input int delay, output int waited);
        wait_start(6, waited);
        chk({tag, "_grant"}, {30'd0, gid}, exp_id);
        chk({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp_data});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_start_1cyc"}, {31'd0, tx_start}, 32'd0);
        repeat (delay - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({tag, "_ack"}, {28'd0, ack}, 32'd1 << exp_id);
        chk({tag, "_no_to"}, {31'd0, timeout}, 32'd0);
        chk({tag, "_data_held"}, {24'd0, tx_data}, {24'd0, exp_data});
        $display("xfer %s: grant=%0d data=0x%02h ack=%b", tag, gid, tx_data, ack);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          w;
        int          k;
        logic        saw_ack;
        int          rr_order [5] = '{0, 1, 2, 3, 0};
        logic [7:0]  rr_data;

        // Reset state and single request with back-to-back repeat.
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);
        chk("rst_gid", {30'd0, gid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        run_xfer("single", 0, 8'hA5, 10, w);
        chk("single_latency", w, 32'd1);
        tick();
        chk("single_ack_1cyc", {28'd0, ack}, 32'd0);
        chk("single_idle_busy", {31'd0, busy}, 32'd0);
        run_xfer("b2b", 0, 8'hA5, 3, w);
        chk("b2b_latency", w, 32'd1);
        req = '0;

        // Round-robin with all four requesting.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        for (int i = 0; i < 5; i++) begin
            rr_data = 8'h10 + 8'(rr_order[i]);
            run_xfer("rr", rr_order[i], rr_data, 4, w);
        end
        req = '0;

        // Watchdog expiry.
        do_reset();
        req      = 4'b0100;
        req_data = 32'h0077_0000;
        wait_start(6, w);
        chk("to_grant", {30'd0, gid}, 32'd2);
        tick();
        k       = 0;
        saw_ack = 1'b0;
        while (!timeout && k < TO + 8) begin
            tick();
            k++;
            if (ack != 4'b0000) saw_ack = 1'b1;
        end
        chk("to_latency", k, TO);
        chk("to_no_ack", {31'd0, saw_ack}, 32'd0);
        $display("xfer timeout: grant=%0d data=0x%02h timeout=%b after %0d cycles", gid, tx_data, timeout, k);
        req = '0;
        tick();
        chk("to_pulse_1cyc", {31'd0, timeout}, 32'd0);
        req      = 4'b1111;
        req_data = 32'h1312_1110;
        wait_start(6, w);
        chk("to_last_grant_next", {30'd0, gid}, 32'd3);

        // Done coincident with watchdog expiry counts as success.
        do_reset();
        req      = 4'b0001;
        req_data = 32'h0000_003C;
        wait_start(6, w);
        tick();
        repeat (TO - 1) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("coin_ack", {28'd0, ack}, 32'd1);
        chk("coin_no_to", {31'd0, timeout}, 32'd0);
        $display("xfer coincident: grant=%0d data=0x%02h ack=%b timeout=%b", gid, tx_data, ack, timeout);
        req = '0;
        tick();
        chk("coin_no_to_after", {31'd0, timeout}, 32'd0);

        // Asynchronous reset during WAIT_DONE.
        do_reset();
        req      = 4'b0110;
        req_data = 32'h00BB_AA00;
        wait_start(6, w);
        chk("mid_grant", {30'd0, gid}, 32'd1);
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_gid", {30'd0, gid}, 32'd0);
        chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        chk("mid_rst_to", {31'd0, timeout}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        wait_start(6, w);
        chk("post_rst_grant", {30'd0, gid}, 32'd1);
        chk("post_rst_data", {24'd0, tx_data}, 32'h0000_00AA);
        $display("xfer reset: first grant after release=%0d data=0x%02h", gid, tx_data);

        // Requester drops and changes data after grant; spurious done in IDLE.
        do_reset();
        req      = 4'b1000;
        req_data = 32'h5C00_0000;
        wait_start(6, w);
        chk("drop_grant", {30'd0, gid}, 32'd3);
        req      = 4'b0000;
        req_data = 32'hFF00_0000;
        tick();
        chk("drop_data_held", {24'd0, tx_data}, 32'h0000_005C);
        repeat (4) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("drop_ack", {28'd0, ack}, 32'h0000_0008);
        chk("drop_data_resp", {24'd0, tx_data}, 32'h0000_005C);
        $display("xfer drop: grant=%0d data=0x%02h ack=%b", gid, tx_data, ack);
        tick();
        chk("drop_idle", {31'd0, busy}, 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("spur_ack", {28'd0, ack}, 32'd0);
        chk("spur_to", {31'd0, timeout}, 32'd0);
        chk("spur_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("spur_ack_later", {28'd0, ack}, 32'd0);
        chk("spur_start", {31'd0, tx_start}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
